// File: rtl/stopwatch_pkg.sv
// Shared state encodings and default timing constants for the stopwatch controller.
package stopwatch_pkg;

    localparam logic [1:0] ST_STOP  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_CLEAR = 2'b10;

    // 100 Hz count rate and 10 ms debounce window at a 100 MHz clk.
    localparam int TICK_DIV_100HZ = 1_000_000;
    localparam int DB_CYCLES_10MS = 1_000_000;

endpackage

// File: rtl/btn_edge_detect.sv
// Button front end: 2-FF synchronizer, optional debounce filter, rising-edge event.
// Build option: define STOPWATCH_DEBOUNCE_EN to insert the DB_CYCLES stability filter.
module btn_edge_detect #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_event
);

    if (DB_CYCLES < 1) begin : g_bad_db_cycles
        $error("btn_edge_detect: DB_CYCLES must be >= 1");
    end

    logic sync1;
    logic sync2;
    logic level;
    logic level_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= i_btn;
            sync2 <= sync1;
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [CW-1:0] stable_cnt;
    logic          filt;

    // Filtered level follows sync2 only after DB_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_cnt <= '0;
            filt       <= 1'b0;
        end else if (sync2 != filt) begin
            if (stable_cnt == CW'(DB_CYCLES - 1)) begin
                filt       <= sync2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end else begin
            stable_cnt <= '0;
        end
    end

    assign level = filt;
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign o_event = level & ~level_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/stop/clear sequencer: issues a count-rate tick enable and a 1-cycle clear pulse.
// Build option: STOPWATCH_DEBOUNCE_EN enables button debouncing in btn_edge_detect.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_100HZ,
    parameter int DB_CYCLES = DB_CYCLES_10MS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run_stop,
    input  logic       btn_clear,
    output logic       o_tick,
    output logic       o_run,
    output logic       o_clear,
    output logic [1:0] o_state
);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("stopwatch_ctrl: TICK_DIV must be >= 2");
    end

    localparam int PW = $clog2(TICK_DIV);

    logic          ev_run_stop;
    logic          ev_clear;
    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [PW-1:0] presc;
    logic          wrap;

    btn_edge_detect #(.DB_CYCLES(DB_CYCLES)) u_btn_run_stop (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (btn_run_stop),
        .o_event (ev_run_stop)
    );

    btn_edge_detect #(.DB_CYCLES(DB_CYCLES)) u_btn_clear (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (btn_clear),
        .o_event (ev_clear)
    );

    // Clear beats run/stop in STOP; in RUN a clear event is dropped, never queued.
    always_comb begin
        state_next = state;
        case (state)
            ST_STOP: begin
                if (ev_clear) begin
                    state_next = ST_CLEAR;
                end else if (ev_run_stop) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ev_run_stop) begin
                    state_next = ST_STOP;
                end
            end
            ST_CLEAR: state_next = ST_STOP;
            default:  state_next = ST_STOP;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_STOP;
        end else begin
            state <= state_next;
        end
    end

    assign wrap = (state == ST_RUN) && (presc == PW'(TICK_DIV - 1));

    // Prescaler holds in STOP so a resumed run finishes the interrupted period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else begin
            case (state)
                ST_CLEAR: presc <= '0;
                ST_RUN:   presc <= wrap ? '0 : presc + PW'(1);
                default:  presc <= presc;
            endcase
        end
    end

    // o_tick and o_clear are single-cycle strobes with no ready/ack: the consumer
    // must act on every cycle they are high, and each strobe is never repeated.
    assign o_tick  = wrap;
    assign o_run   = (state == ST_RUN);
    assign o_clear = (state == ST_CLEAR);
    assign o_state = state;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Run/stop/clear controller that sequences the 0–9999 count datapath from two push-buttons.
- Replaces gated-clock run/stop (clk & sw) with a single-clock design: the block issues a 1-cycle tick enable at the count rate and a 1-cycle clear pulse.
- Sits between the board buttons and the counter; the counter and FND controller stay on clk.

Parameters:
TICK_DIV, 1_000_000, clk cycles per count tick (100 Hz at 100 MHz); legal range >= 2.
DB_CYCLES, 1_000_000, debounce stable-time in clk cycles; used only with STOPWATCH_DEBOUNCE_EN; legal range >= 1.

Ports:
clk  input  1  system clock; all logic on posedge clk
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
btn_run_stop  input  1  raw run/stop button, active-high, asynchronous to clk
btn_clear  input  1  raw clear button, active-high, asynchronous to clk
o_tick  output  1  1-cycle count-enable pulse, only while RUN
o_run  output  1  high while in RUN
o_clear  output  1  1-cycle synchronous clear pulse for the counter
o_state  output  2  FSM state: 2'b00 STOP, 2'b01 RUN, 2'b10 CLEAR

Behaviour:
- Reset (reset=0, async): FSM=STOP; prescaler=0; synchronizer/edge registers=0; o_tick=0, o_run=0, o_clear=0, o_state=2'b00.
- Input path, per button:
  - 2-FF synchronizer, then rising-edge detect: one event per press.
  - Latency: button high to event visible to FSM = 3 clk edges.
  - Holding a button produces no further events.
- FSM transitions, evaluated per cycle:
  - STOP: clear event -> CLEAR; else run_stop event -> RUN; else stay.
  - RUN: run_stop event -> STOP; clear events ignored.
  - CLEAR: unconditional -> STOP after exactly 1 cycle; all events ignored.
  - Simultaneous events in STOP: clear wins. In RUN: run_stop wins; clear is dropped, not queued.
- Outputs are registered and decoded from the current state:
  - o_run=1 iff state==RUN.
  - o_clear=1 iff state==CLEAR, so it is exactly 1 cycle wide.
- Prescaler: $clog2(TICK_DIV)-bit counter.
  - RUN: increments each cycle. At TICK_DIV-1 it wraps to 0 and o_tick=1 for that cycle; first tick comes TICK_DIV cycles after entering RUN from 0.
  - STOP: holds its value, so a resumed run completes the partial period.
  - CLEAR: forced to 0.
  - o_tick is never 1 outside RUN. Leaving RUN on the wrap cycle still yields that final tick, registered in the same cycle.
- Async reset mid-RUN aborts immediately to the reset values; no tick or clear is emitted on release.

Optional Feature:
- Macro: STOPWATCH_DEBOUNCE_EN.
- Defined:
  - Each synchronized button feeds a stability counter; the filtered level changes only after the synced level differs from it for DB_CYCLES consecutive cycles.
  - The edge detect runs on the filtered level.
  - Latency from a clean press to event = DB_CYCLES + 3 cycles.
  - Glitches shorter than DB_CYCLES produce no event.
- Undefined: no filter and no DB_CYCLES counter logic; behaviour exactly as above.

Decomposition:
- Package stopwatch_pkg:
  - state encodings ST_STOP=2'b00, ST_RUN=2'b01, ST_CLEAR=2'b10;
  - default constants TICK_DIV_100HZ=1_000_000 and DB_CYCLES_10MS=1_000_000.
- Sub-module btn_edge_detect, instantiated twice:
  - ports: clk, reset (async active-low), i_btn, o_event;
  - parameter: DB_CYCLES;
  - contains synchronizer, optional debounce and rising-edge logic.
- The FSM and prescaler stay in stopwatch_ctrl.

Test Plan (TICK_DIV=4, DB_CYCLES=3):
- Reset held 0 then released, no buttons -> o_state=00, o_run=0, o_tick=0, o_clear=0 for 20 cycles.
- Pulse btn_run_stop 1 cycle -> o_state=01 three edges later; o_tick pulses every 4th cycle; 5 ticks within 20 cycles of entering RUN.
- In RUN, press run_stop when prescaler=2 -> STOP, prescaler holds 2; press again -> first tick 2 cycles after re-entering RUN.
- In STOP, assert both buttons same cycle -> state 10 for exactly 1 cycle with o_clear=1, then 00; prescaler=0.
- In RUN, press btn_clear alone -> state stays 01, o_clear stays 0, tick cadence unchanged.
- Pull reset low mid-RUN with prescaler=3 -> all outputs 0 asynchronously, before the next clk edge; after release, state 00 and no tick.
- With STOPWATCH_DEBOUNCE_EN: a 2-cycle glitch on btn_run_stop -> no event; a 10-cycle press -> exactly one event at 6 edges after press start.
